// File: rtl/fetch_unit.sv
// Instruction fetch unit: pc register, IF/ID and ID/EX instruction
// registers, stall/branch/halt handling and a saturating stall counter.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   instrData     instruction-memory data for pcAddr (same cycle)
//   pcNotUpdate   stall request from the stall-judgement stage
//   branchTaken   execute-stage redirect request
//   branchTarget  redirect address
//   pcAddr        current pc
//   COMMAND       IF/ID instruction register
//   BeforeCOMMAND ID/EX instruction register
//   stalled       previous edge applied a stall
//   halted        fetch is halted
//   stallCount    saturating stall-cycle count
module fetch_unit #(
    parameter logic [15:0] NOP_WORD  = 16'hC0F0,
    parameter logic [15:0] HALT_WORD = 16'hC0D0,
    parameter logic [15:0] RESET_PC  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instrData,
    input  logic        pcNotUpdate,
    input  logic        branchTaken,
    input  logic [15:0] branchTarget,
    output logic [15:0] pcAddr,
    output logic [15:0] COMMAND,
    output logic [15:0] BeforeCOMMAND,
    output logic        stalled,
    output logic        halted,
    output logic [7:0]  stallCount
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] cmd_q, cmd_d;
    logic [15:0] bcmd_q, bcmd_d;
    logic        stalled_q, stalled_d;
    logic        halted_q;
    logic [7:0]  cnt_q, cnt_d;

    // Every path except a normal advance pushes a bubble into ID/EX,
    // so the bubble is the default for BeforeCOMMAND.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cmd_d     = cmd_q;
        bcmd_d    = NOP_WORD;
        stalled_d = 1'b0;
        cnt_d     = cnt_q;
        unique case (state_q)
            RUN: begin
                if (branchTaken) begin
                    // Flush; a halt word on the flushed path is discarded.
                    pc_d  = branchTarget;
                    cmd_d = NOP_WORD;
                end else if (pcNotUpdate) begin
                    stalled_d = 1'b1;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (cmd_q == HALT_WORD) begin
                    state_d = HALT;
                end else begin
                    pc_d   = pc_q + 16'd1;
                    cmd_d  = instrData;
                    bcmd_d = cmd_q;
                end
            end
            HALT: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            cmd_q     <= NOP_WORD;
            bcmd_q    <= NOP_WORD;
            stalled_q <= 1'b0;
            halted_q  <= 1'b0;
            cnt_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cmd_q     <= cmd_d;
            bcmd_q    <= bcmd_d;
            stalled_q <= stalled_d;
            halted_q  <= (state_d == HALT);
            cnt_q     <= cnt_d;
        end
    end

    assign pcAddr        = pc_q;
    assign COMMAND       = cmd_q;
    assign BeforeCOMMAND = bcmd_q;
    assign stalled       = stalled_q;
    assign halted        = halted_q;
    assign stallCount    = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table plus hand sequences
// for halt, async reset, counter saturation and pc wrap.
module tb_fetch_unit;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] cmd;
        logic [15:0] bcmd;
        logic        stl;
        logic        hlt;
        logic [7:0]  cnt;
    } exp_t;

    typedef struct packed {
        logic        br;
        logic        st;
        logic [15:0] tgt;
        exp_t        e;
    } vec_t;

    localparam logic [15:0] NOP = 16'hC0F0;
    localparam logic [15:0] HLT = 16'hC0D0;

    logic        clk;
    logic        rst;
    logic [15:0] instrData;
    logic        pcNotUpdate;
    logic        branchTaken;
    logic [15:0] branchTarget;
    logic [15:0] pcAddr;
    logic [15:0] COMMAND;
    logic [15:0] BeforeCOMMAND;
    logic        stalled;
    logic        halted;
    logic [7:0]  stallCount;

    logic [15:0] mem [256];
    exp_t        sb [$];
    vec_t        tbl [18];
    int          checks;
    int          failures;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .instrData    (instrData),
        .pcNotUpdate  (pcNotUpdate),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .pcAddr       (pcAddr),
        .COMMAND      (COMMAND),
        .BeforeCOMMAND(BeforeCOMMAND),
        .stalled      (stalled),
        .halted       (halted),
        .stallCount   (stallCount)
    );

    assign instrData = mem[pcAddr[7:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk(logic [15:0] pc, logic [15:0] cmd,
                                logic [15:0] bcmd, logic stl,
                                logic hlt, logic [7:0] cnt);
        exp_t e;
        e.pc = pc; e.cmd = cmd; e.bcmd = bcmd;
        e.stl = stl; e.hlt = hlt; e.cnt = cnt;
        return e;
    endfunction

    function automatic vec_t mv(logic br, logic st, logic [15:0] tgt,
                                exp_t e);
        vec_t v;
        v.br = br; v.st = st; v.tgt = tgt; v.e = e;
        return v;
    endfunction

    task automatic cmp(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h",
                     name, $time, act, exp);
        end
    endtask

    task automatic check_out(string tag);
        exp_t e;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        cmp({tag, ".pcAddr"}, pcAddr, e.pc);
        cmp({tag, ".COMMAND"}, COMMAND, e.cmd);
        cmp({tag, ".BeforeCOMMAND"}, BeforeCOMMAND, e.bcmd);
        cmp({tag, ".stalled"}, {15'd0, stalled}, {15'd0, e.stl});
        cmp({tag, ".halted"}, {15'd0, halted}, {15'd0, e.hlt});
        cmp({tag, ".stallCount"}, {8'd0, stallCount}, {8'd0, e.cnt});
    endtask

    task automatic apply(string tag, logic br, logic st,
                         logic [15:0] tgt, exp_t e);
        branchTaken  = br;
        pcNotUpdate  = st;
        branchTarget = tgt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic expect_now(string tag, exp_t e);
        sb.push_back(e);
        check_out(tag);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h1111; mem[8'h01] = 16'h2222;
        mem[8'h02] = 16'h3333; mem[8'h03] = 16'h4444;
        mem[8'h04] = 16'h5555; mem[8'h05] = 16'h6666;
        mem[8'h10] = 16'h1234; mem[8'h11] = HLT;
        mem[8'h40] = 16'h0A0A; mem[8'h41] = 16'h0B0B;
        mem[8'h42] = HLT;      mem[8'hFF] = 16'hABCD;

        tbl[0]  = mv(0, 0, 16'h0, mk(16'h01, 16'h1111, NOP, 0, 0, 0));
        tbl[1]  = mv(0, 0, 16'h0, mk(16'h02, 16'h2222, 16'h1111, 0, 0, 0));
        tbl[2]  = mv(0, 0, 16'h0, mk(16'h03, 16'h3333, 16'h2222, 0, 0, 0));
        tbl[3]  = mv(0, 0, 16'h0, mk(16'h04, 16'h4444, 16'h3333, 0, 0, 0));
        tbl[4]  = mv(0, 0, 16'h0, mk(16'h05, 16'h5555, 16'h4444, 0, 0, 0));
        tbl[5]  = mv(0, 1, 16'h0, mk(16'h05, 16'h5555, NOP, 1, 0, 1));
        tbl[6]  = mv(0, 0, 16'h0, mk(16'h06, 16'h6666, 16'h5555, 0, 0, 1));
        tbl[7]  = mv(1, 1, 16'h40, mk(16'h40, NOP, NOP, 0, 0, 1));
        tbl[8]  = mv(0, 0, 16'h0, mk(16'h41, 16'h0A0A, NOP, 0, 0, 1));
        tbl[9]  = mv(0, 1, 16'h0, mk(16'h41, 16'h0A0A, NOP, 1, 0, 2));
        tbl[10] = mv(0, 1, 16'h0, mk(16'h41, 16'h0A0A, NOP, 1, 0, 3));
        tbl[11] = mv(0, 0, 16'h0, mk(16'h42, 16'h0B0B, 16'h0A0A, 0, 0, 3));
        tbl[12] = mv(0, 0, 16'h0, mk(16'h43, HLT, 16'h0B0B, 0, 0, 3));
        tbl[13] = mv(1, 0, 16'h10, mk(16'h10, NOP, NOP, 0, 0, 3));
        tbl[14] = mv(0, 0, 16'h0, mk(16'h11, 16'h1234, NOP, 0, 0, 3));
        tbl[15] = mv(0, 0, 16'h0, mk(16'h12, HLT, 16'h1234, 0, 0, 3));
        tbl[16] = mv(0, 1, 16'h0, mk(16'h12, HLT, NOP, 1, 0, 4));
        tbl[17] = mv(0, 0, 16'h0, mk(16'h12, HLT, NOP, 0, 1, 4));

        rst = 1'b1;
        pcNotUpdate = 1'b0;
        branchTaken = 1'b0;
        branchTarget = 16'h0;
        @(posedge clk);
        #1;
        expect_now("reset", mk(16'h0, NOP, NOP, 0, 0, 0));
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].br, tbl[i].st,
                  tbl[i].tgt, tbl[i].e);
        end

        for (int i = 0; i < 10; i++) begin
            apply($sformatf("halt%0d", i), i[0], i[1], 16'h0077,
                  mk(16'h12, HLT, NOP, 0, 1, 4));
        end

        rst = 1'b1;
        #1;
        expect_now("rst2", mk(16'h0, NOP, NOP, 0, 0, 0));
        rst = 1'b0;
        apply("first", 0, 0, 16'h0, mk(16'h01, 16'h1111, NOP, 0, 0, 0));
        apply("prestl", 0, 1, 16'h0, mk(16'h01, 16'h1111, NOP, 1, 0, 1));
        #2;
        rst = 1'b1;
        #1;
        expect_now("asyncrst", mk(16'h0, NOP, NOP, 0, 0, 0));
        rst = 1'b0;
        apply("postrst", 0, 0, 16'h0, mk(16'h01, 16'h1111, NOP, 0, 0, 0));

        for (int i = 0; i < 300; i++) begin
            apply($sformatf("sat%0d", i), 0, 1, 16'h0,
                  mk(16'h01, 16'h1111, NOP, 1, 0,
                     (i >= 254) ? 8'hFF : 8'(i + 1)));
        end

        apply("brFFFF", 1, 0, 16'hFFFF, mk(16'hFFFF, NOP, NOP, 0, 0, 8'hFF));
        apply("wrap0", 0, 0, 16'h0, mk(16'h0000, 16'hABCD, NOP, 0, 0, 8'hFF));
        apply("wrap1", 0, 0, 16'h0,
              mk(16'h0001, 16'h1111, 16'hABCD, 0, 0, 8'hFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter NOP_WORD, default 16'hC0F0: bubble word injected into COMMAND/BeforeCOMMAND; [15:14]=11, so it never triggers a stall as BeforeCOMMAND.
REQ-002 Parameter HALT_WORD, default 16'hC0D0: instruction that halts fetch when it reaches COMMAND.
REQ-003 Parameter RESET_PC, default 16'h0000: pc value after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 instrData  input  16  instruction-memory read data for address pcAddr, valid in the same cycle.
REQ-007 pcNotUpdate  input  1  stall request from the stall-judgement stage, combinational from COMMAND/BeforeCOMMAND.
REQ-008 branchTaken  input  1  execute-stage redirect request.
REQ-009 branchTarget  input  16  redirect address, sampled when branchTaken=1.
REQ-010 pcAddr  output  16  current pc, driven directly from the pc register.
REQ-011 COMMAND  output  16  IF/ID instruction register.
REQ-012 BeforeCOMMAND  output  16  ID/EX instruction register.
REQ-013 stalled  output  1  registered; 1 if the previous edge applied a stall.
REQ-014 halted  output  1  registered; 1 while in state HALT.
REQ-015 stallCount  output  8  saturating count of stall cycles since reset.

Function
REQ-016 FSM states: RUN, HALT; the only exit from HALT is rst.
REQ-017 Per-edge priority in RUN: branchTaken > pcNotUpdate > halt detect > normal.
REQ-018 Normal (RUN, no event): pc <= pc+1; COMMAND <= instrData; BeforeCOMMAND <= COMMAND; stalled <= 0.
REQ-019 pc addition is modulo 2^16; 16'hFFFF wraps to 16'h0000 with no flag.
REQ-020 Stall (pcNotUpdate=1, branchTaken=0): pc and COMMAND hold; BeforeCOMMAND <= NOP_WORD; stalled <= 1; stallCount <= stallCount+1, saturating at 8'hFF.
REQ-021 Stall consequence: the bubble clears BeforeCOMMAND[15:14]==00, so a single hazard costs exactly one cycle.
REQ-022 Branch (branchTaken=1): pc <= branchTarget; COMMAND <= NOP_WORD; BeforeCOMMAND <= NOP_WORD; stalled <= 0; state stays RUN; a simultaneous pcNotUpdate is ignored and not counted.
REQ-023 Halt detect (COMMAND==HALT_WORD, no branch, no stall): state <= HALT; pc holds; COMMAND holds HALT_WORD; BeforeCOMMAND <= NOP_WORD.
REQ-024 In HALT: pc, COMMAND and stallCount frozen; BeforeCOMMAND <= NOP_WORD every edge; branchTaken and pcNotUpdate ignored; stalled <= 0.
REQ-025 HALT_WORD arriving in COMMAND in the same cycle as branchTaken does not halt, because it lies on the flushed path.
REQ-026 instrData is sampled only on normal-advance edges; it is don't-care otherwise.
REQ-027 No combinational path from any input to any output.

Reset
REQ-028 On rst=1, immediately and independent of clk: pc=RESET_PC, COMMAND=NOP_WORD, BeforeCOMMAND=NOP_WORD, stalled=0, halted=0, stallCount=0, state=RUN.
REQ-029 rst asserted mid-stall or mid-branch discards the pending update.
REQ-030 The first normal edge after rst deasserts fetches from RESET_PC.

Verification
REQ-031 Straight-line test: mem[0..3]=A,B,C,D, no events -> after edges 1..3, COMMAND=A,B,C; BeforeCOMMAND=NOP,A,B; pcAddr=1,2,3.
REQ-032 Single stall: pcNotUpdate=1 for one cycle with pc=5, COMMAND=X -> next edge: pcAddr=5, COMMAND=X, BeforeCOMMAND=C0F0, stalled=1, stallCount=1; following edge resumes with pcAddr=6.
REQ-033 Branch plus stall: branchTaken=1, branchTarget=16'h0040, pcNotUpdate=1 -> pcAddr=0040, COMMAND=BeforeCOMMAND=C0F0, stallCount unchanged.
REQ-034 Halt: C0D0 reaches COMMAND -> next edge halted=1; after 10 further edges pcAddr is unchanged and BeforeCOMMAND=C0F0, including with branchTaken pulsed during HALT.
REQ-035 Saturation and wrap: 300 forced stall cycles -> stallCount=FF; run from pc=FFFF -> next pcAddr=0000.
REQ-036 Async reset: assert rst between clock edges mid-stall -> outputs reach reset values before the next edge; halted=0 and pcAddr=RESET_PC.
